// File: rtl/print_pkg.sv
// Shared types and constants for the print formatter: FSM states, ASCII codes,
// decimal power table and the compare-chain digit extractor.
package print_pkg;

  typedef enum logic [1:0] {IDLE, DIGIT, NL, SIGN} state_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_NL    = 8'h0A;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;

  localparam int NUM_DIGITS = 5;
  localparam int unsigned POW10 [NUM_DIGITS] = '{10000, 1000, 100, 10, 1};

  function automatic logic [15:0] pow10(input logic [2:0] i);
    case (i)
      3'd0:    return 16'(POW10[0]);
      3'd1:    return 16'(POW10[1]);
      3'd2:    return 16'(POW10[2]);
      3'd3:    return 16'(POW10[3]);
      default: return 16'(POW10[4]);
    endcase
  endfunction

  // floor(v/pow) for a quotient known to be 0..9; compare chain, no divider.
  function automatic logic [3:0] digit_of(input logic [15:0] v, input logic [15:0] pow);
    logic [3:0] d;
    d = '0;
    for (int k = 1; k <= 9; k++)
      if ({4'd0, v} >= 20'(k) * {4'd0, pow}) d = 4'(k);
    return d;
  endfunction

endpackage

// File: rtl/print_formatter_if.sv
// Print value input, character stream output and finish/done status of the formatter.
interface print_formatter_if;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_full;
  logic        overflow;
  logic        finish_in;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        done;

  modport master (output in_valid, in_data, finish_in, out_ready,
                  input  in_full, overflow, out_valid, out_data, done);
  modport slave  (input  in_valid, in_data, finish_in, out_ready,
                  output in_full, overflow, out_valid, out_data, done);
endinterface

// File: rtl/print_fifo.sv
// DEPTH x WIDTH circular buffer; push is dropped when full, pop ignored when empty.
module print_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  // Fullness is judged on the cycle-start count, so a same-cycle pop never frees a slot.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/print_formatter.sv
// Queues print values and streams each as ASCII decimal plus newline.
// Define PRINT_SIGNED_EN to treat values as two's complement with a leading '-'.
module print_formatter
  import print_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input logic               clk,
  input logic               rst,
  print_formatter_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  state_t           state, state_nxt;
  logic [15:0]      val, val_nxt;
  logic [2:0]       idx, idx_nxt;
  logic             started, started_nxt;
  logic             finish_seen, overflow_q, done_q;
  logic             pop, full, empty;
  logic [AW:0]      count;
  logic [WIDTH-1:0] head;
  logic [15:0]      pow;
  logic [3:0]       d;
  logic             emit;
  logic             out_valid;
  logic [7:0]       out_data;

  print_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.in_valid),
    .wdata (bus.in_data),
    .pop   (pop),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign pow  = pow10(idx);
  assign d    = digit_of(val, pow);
  // Leading zeros are suppressed; the units position always prints so 0 gives "0".
  assign emit = (d != 4'd0) | started | (idx == 3'd4);

  always_comb begin
    state_nxt   = state;
    val_nxt     = val;
    idx_nxt     = idx;
    started_nxt = started;
    pop         = 1'b0;
    out_valid   = 1'b0;
    out_data    = 8'h00;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop         = 1'b1;
          idx_nxt     = 3'd0;
          started_nxt = 1'b0;
`ifdef PRINT_SIGNED_EN
          if (head[15]) begin
            val_nxt   = (~head) + 16'd1;
            state_nxt = SIGN;
          end else begin
            val_nxt   = head;
            state_nxt = DIGIT;
          end
`else
          val_nxt   = head;
          state_nxt = DIGIT;
`endif
        end
      end
      SIGN: begin
        out_valid = 1'b1;
        out_data  = ASCII_MINUS;
        if (bus.out_ready) state_nxt = DIGIT;
      end
      DIGIT: begin
        if (emit) begin
          out_valid = 1'b1;
          out_data  = ASCII_ZERO + {4'd0, d};
          if (bus.out_ready) begin
            val_nxt     = val - ({12'd0, d} * pow);
            started_nxt = 1'b1;
            if (idx == 3'd4) state_nxt = NL;
            else             idx_nxt   = idx + 3'd1;
          end
        end else begin
          idx_nxt = idx + 3'd1;
        end
      end
      NL: begin
        out_valid = 1'b1;
        out_data  = ASCII_NL;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val         <= '0;
      idx         <= '0;
      started     <= 1'b0;
      finish_seen <= 1'b0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      val         <= val_nxt;
      idx         <= idx_nxt;
      started     <= started_nxt;
      finish_seen <= finish_seen | bus.finish_in;
      if (bus.in_valid && full) overflow_q <= 1'b1;
      done_q      <= finish_seen && (count == '0) && (state == IDLE);
    end
  end

  assign bus.in_full   = full;
  assign bus.overflow  = overflow_q;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_print_formatter.sv
// Bench for print_formatter: line-level reference model checked every cycle,
// plus literal expectations on the accepted character stream.
module tb_print_formatter;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  print_formatter_if bus();

  print_formatter #(.DEPTH(DEPTH), .WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  string got = "";

  // Model: values waiting in the FIFO, and the remaining cycles of the current
  // line (-1 marks a cycle spent on a suppressed leading position).
  logic [15:0] mq[$];
  int          mline[$];
  bit          m_ovf, m_fin, m_done, mdl_ok;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic string vis(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++)
      r = (s[i] == 8'h0A) ? {r, "\\n"} : $sformatf("%s%c", r, s[i]);
    return r;
  endfunction

  task automatic chk_str(input string name, input string exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, vis(got), vis(exp));
    end
  endtask

  function automatic void load_line(input logic [15:0] v);
    int unsigned mag;
    string s;
    mag = v;
`ifdef PRINT_SIGNED_EN
    if (v[15]) begin
      mline.push_back(8'h2D);
      mag = 65536 - v;
    end
`endif
    s = $sformatf("%0d", mag);
    for (int i = s.len(); i < 5; i++) mline.push_back(-1);
    for (int i = 0; i < s.len(); i++) mline.push_back(int'(s[i]));
    mline.push_back(10);
  endfunction

  always @(negedge clk) begin
    bit ev, acc, pop_now, push_ok, nd;
    logic [7:0] ed;
    ev = (mline.size() > 0) && (mline[0] != -1);
    ed = ev ? 8'(mline[0]) : 8'h00;
    if (mdl_ok) begin
      chk("out_valid", 16'(bus.out_valid), 16'(ev));
      chk("out_data",  16'(bus.out_data),  16'(ed));
      chk("in_full",   16'(bus.in_full),   16'(mq.size() == DEPTH));
      chk("overflow",  16'(bus.overflow),  16'(m_ovf));
      chk("done",      16'(bus.done),      16'(m_done));
    end
    if (rst) begin
      mq.delete(); mline.delete();
      m_ovf = 0; m_fin = 0; m_done = 0; mdl_ok = 1;
    end else if (mdl_ok) begin
      if (bus.out_valid && bus.out_ready) got = $sformatf("%s%c", got, bus.out_data);
      acc     = ev && bus.out_ready;
      pop_now = (mline.size() == 0) && (mq.size() > 0);
      nd      = m_fin && (mq.size() == 0) && (mline.size() == 0);
      push_ok = bus.in_valid && (mq.size() < DEPTH);
      if (bus.in_valid && !push_ok) m_ovf = 1;
      if (mline.size() > 0 && (mline[0] == -1 || acc)) void'(mline.pop_front());
      if (pop_now) load_line(mq.pop_front());
      if (push_ok) mq.push_back(bus.in_data);
      m_done = nd;
      m_fin  = m_fin | bus.finish_in;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] v);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid = 0; bus.in_data = '0; bus.finish_in = 0; bus.out_ready = 0;
    rst = 1;
    repeat (3) tick();
    chk("rst out_valid", 16'(bus.out_valid), 16'd0);
    chk("rst out_data",  16'(bus.out_data),  16'd0);
    chk("rst in_full",   16'(bus.in_full),   16'd0);
    chk("rst overflow",  16'(bus.overflow),  16'd0);
    chk("rst done",      16'(bus.done),      16'd0);
    rst = 0;

    // zero
    bus.out_ready = 1; got = "";
    push(16'd0);
    repeat (10) tick();
    chk_str("zero", "0\n");
    chk("done before finish", 16'(bus.done), 16'd0);

    // inner zero, no gaps once started
    got = "";
    push(16'd1205);
    repeat (10) tick();
    chk_str("1205", "1205\n");

    // stalled sink
    got = "";
    push(16'd65535);
    for (int i = 0; i < 40; i++) begin
      bus.out_ready = (i % 3 == 0);
      tick();
    end
    bus.out_ready = 1;
    repeat (3) tick();
    chk_str("65535 stalled", "65535\n");

    // fill while the sink is blocked; first value is popped, four more fill the FIFO
    got = ""; bus.out_ready = 0;
    push(16'd11); push(16'd22); push(16'd33); push(16'd44); push(16'd55);
    chk("full after fill", 16'(bus.in_full), 16'd1);
    chk("no overflow yet", 16'(bus.overflow), 16'd0);
    push(16'd66);
    chk("overflow set", 16'(bus.overflow), 16'd1);
    bus.out_ready = 1;
    repeat (60) tick();
    chk_str("drain order", "11\n22\n33\n44\n55\n");
    chk("overflow sticky", 16'(bus.overflow), 16'd1);

    // finish during conversion
    got = "";
    push(16'd7);
    tick();
    bus.finish_in = 1; tick(); bus.finish_in = 0;
    chk("done during conv", 16'(bus.done), 16'd0);
    repeat (12) tick();
    chk("done after drain", 16'(bus.done), 16'd1);
    chk_str("seven", "7\n");

    // strobe after finish
    got = "";
    push(16'd3);
    tick();
    chk("done drops", 16'(bus.done), 16'd0);
    repeat (12) tick();
    chk("done again", 16'(bus.done), 16'd1);
    chk_str("three", "3\n");

    // top-bit values
    got = "";
`ifdef PRINT_SIGNED_EN
    push(16'h8000); push(16'hFFFF);
    repeat (30) tick();
    chk_str("signed", "-32768\n-1\n");
`else
    push(16'hFFFF);
    repeat (20) tick();
    chk_str("ffff", "65535\n");
`endif

    // reset mid-conversion discards in-flight and queued values
    got = "";
    push(16'd12345);
    push(16'd1);
    tick();
    chk("second digit", 16'(bus.out_data), 16'h0032);
    rst = 1; tick(); rst = 0;
    chk("post-rst out_valid", 16'(bus.out_valid), 16'd0);
    chk("post-rst in_full",   16'(bus.in_full),   16'd0);
    chk("post-rst done",      16'(bus.done),      16'd0);
    chk_str("pre-rst chars", "1");
    got = "";
    repeat (15) tick();
    chk_str("nothing after rst", "");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
